// File: rtl/diff_pkg.sv
// diff_pkg: shared mode/state types and saturation bounds for the diff_accum
// gradient accumulator and its per-channel diff_lane datapath.
package diff_pkg;

    typedef enum logic [1:0] {
        DIFF_DENSE  = 2'd0,
        DIFF_START  = 2'd1,
        DIFF_TO_ALL = 2'd2
    } diff_mode_e;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } diff_state_e;

    function automatic logic signed [63:0] sat_max(input int data_size);
        return (64'sd1 <<< (data_size - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int data_size);
        return -(64'sd1 <<< (data_size - 1));
    endfunction

    // The reserved encoding behaves exactly like DENSE.
    function automatic diff_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return DIFF_START;
            2'd2:    return DIFF_TO_ALL;
            default: return DIFF_DENSE;
        endcase
    endfunction

endpackage

// File: rtl/diff_lane.sv
// diff_lane: one channel of diff_accum -- fixed-point multiply, scale, saturate,
// and a saturating accumulator that adds whatever term the top selects.
module diff_lane
    import diff_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DATA_SIZE-1:0] delta,
    input  logic signed [DATA_SIZE-1:0] operand,
    input  logic signed [DATA_SIZE-1:0] term,
    input  logic                        acc_en,
    input  logic                        clear,
    output logic signed [DATA_SIZE-1:0] prod,
    output logic                        prod_sat,
    output logic signed [DATA_SIZE-1:0] acc,
    output logic                        acc_sat
);

    localparam int PW = 2 * DATA_SIZE;
    localparam int SW = DATA_SIZE + 1;

    localparam logic signed [PW-1:0]        P_MAX = PW'(sat_max(DATA_SIZE));
    localparam logic signed [PW-1:0]        P_MIN = PW'(sat_min(DATA_SIZE));
    localparam logic signed [SW-1:0]        S_MAX = SW'(sat_max(DATA_SIZE));
    localparam logic signed [SW-1:0]        S_MIN = SW'(sat_min(DATA_SIZE));
    localparam logic signed [DATA_SIZE-1:0] D_MAX = DATA_SIZE'(sat_max(DATA_SIZE));
    localparam logic signed [DATA_SIZE-1:0] D_MIN = DATA_SIZE'(sat_min(DATA_SIZE));

    logic signed [PW-1:0]        full;
    logic signed [PW-1:0]        scaled;
    logic signed [SW-1:0]        sum;
    logic signed [DATA_SIZE-1:0] acc_next;

    assign full   = PW'(delta) * PW'(operand);
    assign scaled = full >>> FRAC_BITS;
    assign sum    = SW'(acc) + SW'(term);

    always_comb begin
        prod     = scaled[DATA_SIZE-1:0];
        prod_sat = 1'b0;
        if (scaled > P_MAX) begin
            prod     = D_MAX;
            prod_sat = 1'b1;
        end else if (scaled < P_MIN) begin
            prod     = D_MIN;
            prod_sat = 1'b1;
        end
    end

    always_comb begin
        acc_next = sum[DATA_SIZE-1:0];
        acc_sat  = 1'b0;
        if (sum > S_MAX) begin
            acc_next = D_MAX;
            acc_sat  = 1'b1;
        end else if (sum < S_MIN) begin
            acc_next = D_MIN;
            acc_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/diff_accum.sv
// diff_accum: batched per-channel gradient accumulator with valid/ready on both sides.
// Define DIFF_ACCUM_AVG_EN to present each sum divided by BATCH instead of the raw sum.
module diff_accum
    import diff_pkg::*;
#(
    parameter int SIZE      = 3,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int BATCH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mode,
    input  logic [DATA_SIZE-1:0]      delta,
    input  logic [SIZE*DATA_SIZE-1:0] weight,
    input  logic [SIZE*DATA_SIZE-1:0] x,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIZE*DATA_SIZE-1:0] grad,
    output logic                      sat
);

    localparam int CW        = $clog2(BATCH);
    localparam int AVG_SHIFT = $clog2(BATCH);
    localparam int SUMW      = DATA_SIZE + $clog2(SIZE) + 1;

    localparam logic [CW-1:0]                LAST    = CW'(BATCH - 1);
    localparam logic signed [SUMW-1:0]       SUM_MAX = SUMW'(sat_max(DATA_SIZE));
    localparam logic signed [SUMW-1:0]       SUM_MIN = SUMW'(sat_min(DATA_SIZE));
    localparam logic signed [DATA_SIZE-1:0]  D_MAX   = DATA_SIZE'(sat_max(DATA_SIZE));
    localparam logic signed [DATA_SIZE-1:0]  D_MIN   = DATA_SIZE'(sat_min(DATA_SIZE));

    diff_state_e state;
    diff_state_e state_next;
    diff_mode_e  mode_q;
    diff_mode_e  eff_mode;

    logic [CW-1:0] count;
    logic          started;
    logic          sat_flag;
    logic          accept;
    logic          handshake;
    logic          sum_sat;
    logic          sample_sat;

    logic signed [DATA_SIZE-1:0] lane_prod [SIZE];
    logic signed [DATA_SIZE-1:0] lane_acc  [SIZE];
    logic [SIZE-1:0]             lane_prod_sat;
    logic [SIZE-1:0]             lane_acc_sat;
    logic signed [SUMW-1:0]      sum_wide;
    logic signed [DATA_SIZE-1:0] to_all_term;

    // started holds in_ready low until the first edge after reset release.
    assign in_ready  = (state == ST_ACC) && started;
    assign out_valid = (state == ST_OUT);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign sat       = sat_flag;
    assign eff_mode  = (count == '0) ? decode_mode(mode) : mode_q;

    always_comb begin
        sum_wide = '0;
        for (int i = 0; i < SIZE; i++) begin
            sum_wide = sum_wide + SUMW'(lane_prod[i]);
        end
        to_all_term = sum_wide[DATA_SIZE-1:0];
        sum_sat     = 1'b0;
        if (sum_wide > SUM_MAX) begin
            to_all_term = D_MAX;
            sum_sat     = 1'b1;
        end else if (sum_wide < SUM_MIN) begin
            to_all_term = D_MIN;
            sum_sat     = 1'b1;
        end
    end

    assign sample_sat = (|lane_prod_sat) || (|lane_acc_sat) ||
                        ((eff_mode == DIFF_TO_ALL) && sum_sat);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic signed [DATA_SIZE-1:0] operand;
        logic signed [DATA_SIZE-1:0] term;

        assign operand = (eff_mode == DIFF_DENSE) ? x[i*DATA_SIZE +: DATA_SIZE]
                                                  : weight[i*DATA_SIZE +: DATA_SIZE];
        assign term    = (eff_mode == DIFF_TO_ALL) ? to_all_term : lane_prod[i];

        diff_lane #(
            .DATA_SIZE(DATA_SIZE),
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .delta   (delta),
            .operand (operand),
            .term    (term),
            .acc_en  (accept),
            .clear   (handshake),
            .prod    (lane_prod[i]),
            .prod_sat(lane_prod_sat[i]),
            .acc     (lane_acc[i]),
            .acc_sat (lane_acc_sat[i])
        );

`ifdef DIFF_ACCUM_AVG_EN
        assign grad[i*DATA_SIZE +: DATA_SIZE] = lane_acc[i] >>> AVG_SHIFT;
`else
        assign grad[i*DATA_SIZE +: DATA_SIZE] = lane_acc[i];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // A flush with nothing accepted yet is ignored so an empty batch is never presented.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC: begin
                if (accept && (flush || count == LAST)) begin
                    state_next = ST_OUT;
                end else if (!accept && flush && count != '0) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            count    <= '0;
            sat_flag <= 1'b0;
            mode_q   <= DIFF_DENSE;
        end else begin
            started <= 1'b1;
            if (handshake) begin
                count    <= '0;
                sat_flag <= 1'b0;
            end else if (accept) begin
                count <= count + CW'(1);
                if (count == '0) begin
                    mode_q <= eff_mode;
                end
                if (sample_sat) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_diff_accum.sv
// tb_diff_accum: scoreboard bench for diff_accum at SIZE=3, DATA_SIZE=16, FRAC_BITS=8, BATCH=4.
// Honours DIFF_ACCUM_AVG_EN when building expected gradients.
module tb_diff_accum;

    localparam int SIZE = 3;
    localparam int DS   = 16;
    localparam int NB   = 4;

    typedef struct packed {
        logic [SIZE*DS-1:0] grad;
        logic               sat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [DS-1:0]      delta;
    logic [SIZE*DS-1:0] weight;
    logic [SIZE*DS-1:0] x;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [SIZE*DS-1:0] grad;
    logic               sat;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    longint     mdl_acc[SIZE];
    bit         mdl_sat;
    int         mdl_cnt;
    logic [1:0] mdl_mode;

    diff_accum #(
        .SIZE(SIZE), .DATA_SIZE(DS), .FRAC_BITS(8), .BATCH(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .delta(delta), .weight(weight), .x(x), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .grad(grad), .sat(sat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint clip(input longint v, inout bit f);
        if (v > 32767) begin f = 1'b1; return 32767; end
        if (v < -32768) begin f = 1'b1; return -32768; end
        return v;
    endfunction

    function automatic logic [SIZE*DS-1:0] pack_grad(input longint g0, input longint g1, input longint g2);
        longint g[SIZE];
        logic [SIZE*DS-1:0] r;
        g = '{g0, g1, g2};
        for (int i = 0; i < SIZE; i++) begin
`ifdef DIFF_ACCUM_AVG_EN
            g[i] = g[i] >>> 2;
`endif
            r[i*DS +: DS] = 16'(g[i]);
        end
        return r;
    endfunction

    function automatic int rnd16();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 1023)) - 512;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SIZE; i++) mdl_acc[i] = 0;
        mdl_sat = 1'b0;
        mdl_cnt = 0;
    endtask

    task automatic model_step();
        longint p[SIZE];
        longint s;
        logic [SIZE*DS-1:0] op;
        if (mdl_cnt == 0) mdl_mode = (mode == 2'd3) ? 2'd0 : mode;
        op = (mdl_mode == 2'd0) ? x : weight;
        s = 0;
        for (int i = 0; i < SIZE; i++) begin
            p[i] = clip((longint'($signed(delta)) * longint'($signed(op[i*DS +: DS]))) >>> 8, mdl_sat);
            s += p[i];
        end
        s = clip(s, mdl_sat);
        for (int i = 0; i < SIZE; i++) begin
            mdl_acc[i] = clip(mdl_acc[i] + ((mdl_mode == 2'd2) ? s : p[i]), mdl_sat);
        end
        mdl_cnt++;
    endtask

    // Presents one sample from a falling edge and returns 1ns after the edge that takes it.
    task automatic drive_sample(input logic [1:0] m, input int d, input int w0, input int w1,
                                input int w2, input int x0, input int x1, input int x2, input bit fl);
        int waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accept_wait got=%b want=1", in_ready);
        end
        mode     = m;
        delta    = 16'(d);
        weight   = {16'(w2), 16'(w1), 16'(w0)};
        x        = {16'(x2), 16'(x1), 16'(x0)};
        flush    = fl;
        in_valid = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_out_valid(output bit ok);
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        ok = out_valid;
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        model_clear();
    endtask

    task automatic dense_batch();
        for (int k = 0; k < NB; k++) drive_sample(2'd0, 256, 0, 0, 0, 512, -256, 128, 1'b0);
        sb.push_back('{grad: pack_grad(2048, -1024, 512), sat: 1'b0});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; mode = 2'd0; delta = '0; weight = '0; x = '0;
        flush = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, in_ready, sat} !== 3'b000 || grad !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b%b%b/%h want=000/0", out_valid, in_ready, sat, grad);
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_before_edge got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_edge got=%b want=1", in_ready);
        end
    endtask

    task automatic test_dense();
        exp_t e;
        bit   ok;
        dense_batch();
        wait_out_valid(ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL dense_valid got=%b want=1", out_valid); end
        e = sb.pop_front();
        checks++;
        if (grad !== e.grad) begin failures++; $display("[TB] FAIL dense_grad got=%h want=%h", grad, e.grad); end
        checks++;
        if (sat !== e.sat) begin failures++; $display("[TB] FAIL dense_sat got=%b want=%b", sat, e.sat); end
        do_handshake();
    endtask

    task automatic test_saturation();
        exp_t e;
        bit   ok;
        for (int k = 0; k < NB; k++) drive_sample(2'd0, 32767, 0, 0, 0, 32767, 0, 0, 1'b0);
        sb.push_back('{grad: pack_grad(32767, 0, 0), sat: 1'b1});
        wait_out_valid(ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL sat_valid got=%b want=1", out_valid); end
        e = sb.pop_front();
        checks++;
        if (grad !== e.grad) begin failures++; $display("[TB] FAIL sat_grad got=%h want=%h", grad, e.grad); end
        checks++;
        if (sat !== e.sat) begin failures++; $display("[TB] FAIL sat_flag got=%b want=%b", sat, e.sat); end
        do_handshake();
    endtask

    task automatic test_to_all();
        exp_t e;
        drive_sample(2'd2, 256, 256, 512, 768, 0, 0, 0, 1'b1);
        sb.push_back('{grad: pack_grad(1536, 1536, 1536), sat: 1'b0});
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL to_all_latency got=%b want=1", out_valid);
        end
        e = sb.pop_front();
        checks++;
        if (grad !== e.grad) begin failures++; $display("[TB] FAIL to_all_grad got=%h want=%h", grad, e.grad); end
        checks++;
        if (sat !== e.sat) begin failures++; $display("[TB] FAIL to_all_sat got=%b want=%b", sat, e.sat); end
        do_handshake();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        dense_batch();
        wait_out_valid(ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL bp_valid got=%b want=1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (grad !== e.grad || sat !== e.sat || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL bp_hold cycle=%0d got=%h/%b/%b/%b want=%h/%b/0/1",
                         c, grad, sat, in_ready, out_valid, e.grad, e.sat);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_hs_ready got=%b want=0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        model_clear();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || grad !== '0) begin
            failures++;
            $display("[TB] FAIL bp_release got=%b/%b/%h want=1/0/0", in_ready, out_valid, grad);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        for (int k = 0; k < 2; k++) drive_sample(2'd0, 256, 0, 0, 0, 512, -256, 128, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, sat} !== 3'b000 || grad !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got=%b%b%b/%h want=000/0", out_valid, in_ready, sat, grad);
        end
        model_clear();
        @(negedge clk);
        #2 rst_n = 1'b1;
        dense_batch();
        wait_out_valid(ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL midreset_valid got=%b want=1", out_valid); end
        e = sb.pop_front();
        checks++;
        if (grad !== e.grad) begin failures++; $display("[TB] FAIL midreset_grad got=%h want=%h", grad, e.grad); end
        do_handshake();
    endtask

    task automatic test_mode_change();
        exp_t e;
        bit   ok;
        drive_sample(2'd0, 256, 1000, 1000, 1000, 512, -256, 128, 1'b0);
        for (int k = 1; k < NB; k++) drive_sample(2'd1, 256, 1000, 1000, 1000, 512, -256, 128, 1'b0);
        sb.push_back('{grad: pack_grad(2048, -1024, 512), sat: 1'b0});
        wait_out_valid(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || grad !== e.grad) begin
            failures++;
            $display("[TB] FAIL mode_latch got=%b/%h want=1/%h", out_valid, grad, e.grad);
        end
        do_handshake();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL empty_flush cycle=%0d got=%b want=0", c, out_valid);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        bit   ok;
        int   n;
        for (int b = 0; b < 6; b++) begin
            n = int'($urandom_range(1, NB));
            for (int k = 1; k <= n; k++) begin
                drive_sample(2'($urandom_range(0, 3)), rnd16(), rnd16(), rnd16(), rnd16(),
                             rnd16(), rnd16(), rnd16(), (k == n) && (n < NB));
            end
            sb.push_back('{grad: pack_grad(mdl_acc[0], mdl_acc[1], mdl_acc[2]), sat: mdl_sat});
            wait_out_valid(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || grad !== e.grad || sat !== e.sat) begin
                failures++;
                $display("[TB] FAIL random batch=%0d got=%b/%h/%b want=1/%h/%b",
                         b, out_valid, grad, sat, e.grad, e.sat);
            end
            do_handshake();
        end
    endtask

    initial begin
        test_reset();
        test_dense();
        test_saturation();
        test_to_all();
        test_backpressure();
        test_reset_mid();
        test_mode_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
